// File: rtl/vram_fill_ctrl.sv
// Rectangle fill engine for the menu name-table/attribute RAM pair, sharing
// RAM port A with CPU single-byte writes (CPU always wins the port).
module vram_fill_ctrl #(
  parameter int COLS = 32,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_we,
  input  logic [2:0]  reg_addr,
  input  logic [7:0]  reg_di,
  output logic [7:0]  reg_do,
  input  logic        cpu_req,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  input  logic [3:0]  cpu_atr,
  output logic        ram_we,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_dat,
  output logic [3:0]  ram_atr,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [5:0] COLS_W = 6'(COLS);
  localparam logic [4:0] ROWS_W = 5'(ROWS);

  state_t      state_r, state_nx_s;
  logic [4:0]  x_r, y_r, h_r;
  logic [5:0]  w_r;
  logic [7:0]  tile_r, tile_c_r;
  logic [3:0]  atr_r, atr_c_r;
  logic        nt_r, err_r, eng_wr_r;
  logic [4:0]  x_c_r, ye_r, col_r, row_r;
  logic [5:0]  xe_r;
  logic        ctrl_wr_s, start_s, abort_s, geo_err_s, last_s;
  logic [5:0]  col_room_s, wc_s, xe_s;
  logic [4:0]  row_room_s, hc_s, ye_s, col_nx_s, row_nx_s;
  logic [7:0]  eng_tile_s;
  logic [3:0]  eng_atr_s;

  assign ctrl_wr_s  = reg_we && (reg_addr == 3'd6);
  assign start_s    = ctrl_wr_s && reg_di[0] && !reg_di[1];
  assign abort_s    = ctrl_wr_s && reg_di[1];

  // Clipped extents; no wrap past the right edge or the last visible row.
  assign col_room_s = COLS_W - {1'b0, x_r};
  assign row_room_s = ROWS_W - y_r;
  assign wc_s       = (w_r < col_room_s) ? w_r : col_room_s;
  assign hc_s       = (h_r < row_room_s) ? h_r : row_room_s;
  assign xe_s       = {1'b0, x_r} + wc_s - 6'd1;
  assign ye_s       = y_r + hc_s - 5'd1;
  assign geo_err_s  = (w_r == 6'd0) || (h_r == 5'd0) ||
                      ({1'b0, x_r} >= COLS_W) || (y_r >= ROWS_W);
  assign last_s     = ({1'b0, col_r} == xe_r) && (row_r == ye_r);

  // CPU-visible register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= 5'd0;
      y_r    <= 5'd0;
      w_r    <= 6'd0;
      h_r    <= 5'd0;
      tile_r <= 8'd0;
      atr_r  <= 4'd0;
    end else if (reg_we) begin
      case (reg_addr)
        3'd0:    x_r    <= reg_di[4:0];
        3'd1:    y_r    <= reg_di[4:0];
        3'd2:    w_r    <= reg_di[5:0];
        3'd3:    h_r    <= reg_di[4:0];
        3'd4:    tile_r <= reg_di;
        3'd5:    atr_r  <= reg_di[3:0];
        default: ;
      endcase
    end
  end

  // Register read mux.
  always_comb begin
    reg_do = 8'd0;
    case (reg_addr)
      3'd0:    reg_do = {3'd0, x_r};
      3'd1:    reg_do = {3'd0, y_r};
      3'd2:    reg_do = {2'd0, w_r};
      3'd3:    reg_do = {3'd0, h_r};
      3'd4:    reg_do = tile_r;
      3'd5:    reg_do = {4'd0, atr_r};
      3'd6:    reg_do = {5'd0, nt_r, err_r, busy};
      default: reg_do = 8'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state; a RUN cycle only retires a cell when the port carried an engine write.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) state_nx_s = S_LOAD;
        else         state_nx_s = S_IDLE;
      end
      S_LOAD: begin
        if (abort_s || geo_err_s) state_nx_s = S_DONE;
        else                      state_nx_s = S_RUN;
      end
      S_RUN: begin
        if (abort_s)                 state_nx_s = S_DONE;
        else if (eng_wr_r && last_s) state_nx_s = S_DONE;
        else                         state_nx_s = S_RUN;
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_r != S_IDLE);
    done = (state_r == S_DONE);
  end

  // Cursor for the next engine write.
  always_comb begin
    col_nx_s = col_r;
    row_nx_s = row_r;
    if (state_r == S_LOAD) begin
      col_nx_s = x_r;
      row_nx_s = y_r;
    end else if ((state_r == S_RUN) && eng_wr_r) begin
      if ({1'b0, col_r} == xe_r) begin
        col_nx_s = x_c_r;
        row_nx_s = row_r + 5'd1;
      end else begin
        col_nx_s = col_r + 5'd1;
        row_nx_s = row_r;
      end
    end else begin
      col_nx_s = col_r;
      row_nx_s = row_r;
    end
    eng_tile_s = (state_r == S_LOAD) ? tile_r : tile_c_r;
    eng_atr_s  = (state_r == S_LOAD) ? atr_r  : atr_c_r;
  end

  // Fill context: latched geometry copies, cursor, status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_c_r    <= 5'd0;
      xe_r     <= 6'd0;
      ye_r     <= 5'd0;
      tile_c_r <= 8'd0;
      atr_c_r  <= 4'd0;
      col_r    <= 5'd0;
      row_r    <= 5'd0;
      nt_r     <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      col_r <= col_nx_s;
      row_r <= row_nx_s;
      if (state_r == S_LOAD) begin
        x_c_r    <= x_r;
        xe_r     <= xe_s;
        ye_r     <= ye_s;
        tile_c_r <= tile_r;
        atr_c_r  <= atr_r;
      end
      if ((state_r == S_IDLE) && start_s) begin
        nt_r  <= reg_di[2];
        err_r <= 1'b0;
      end else if ((state_r == S_LOAD) && !abort_s && geo_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Registered RAM port: loaded one cycle ahead with the write it will carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we   <= 1'b0;
      ram_addr <= 11'd0;
      ram_dat  <= 8'd0;
      ram_atr  <= 4'd0;
      eng_wr_r <= 1'b0;
    end else if (cpu_req) begin
      ram_we   <= 1'b1;
      ram_addr <= cpu_addr;
      ram_dat  <= cpu_dat;
      ram_atr  <= cpu_atr;
      eng_wr_r <= 1'b0;
    end else if (state_nx_s == S_RUN) begin
      ram_we   <= 1'b1;
      ram_addr <= {nt_r, row_nx_s, col_nx_s};
      ram_dat  <= eng_tile_s;
      ram_atr  <= eng_atr_s;
      eng_wr_r <= 1'b1;
    end else begin
      ram_we   <= 1'b0;
      eng_wr_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Directed bench for vram_fill_ctrl: register vector table plus fill,
// clipping, error, CPU-priority, abort and reset sequences.
module tb_vram_fill_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, reg_we, cpu_req;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_di, reg_do, cpu_dat, ram_dat, v;
  logic [10:0] cpu_addr, ram_addr;
  logic [3:0]  cpu_atr, ram_atr;
  logic        ram_we, busy, done;

  vram_fill_ctrl #(.COLS(32), .ROWS(30)) dut (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_addr(reg_addr), .reg_di(reg_di),
    .reg_do(reg_do), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
    .cpu_atr(cpu_atr), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dat(ram_dat),
    .ram_atr(ram_atr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  dat;
    logic [3:0]  atr;
    int          rel;
  } wr_t;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] di;
    logic [7:0] exp_do;
    logic       exp_busy;
  } vec_t;

  wr_t  wlog[$];
  vec_t vt[10];
  int   start_cyc, done_rel, done_cnt;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [10:0] cexp[7];

  // Port monitor: cycle numbers are relative to the start pulse (pulse = cycle 0).
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) wlog.push_back('{ram_addr, ram_dat, ram_atr, cyc - start_cyc});
      if (done) begin
        if (done_cnt == 0) done_rel = cyc - start_cyc;
        done_cnt++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    reg_we = 1'b1; reg_addr = a; reg_di = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a;
    #1;
    d = reg_do;
  endtask

  task automatic start_fill(input logic [7:0] ctrl);
    @(posedge clk); #1;
    wlog.delete(); done_cnt = 0; done_rel = -1;
    reg_we = 1'b1; reg_addr = 3'd6; reg_di = ctrl;
    @(posedge clk); #1;
    reg_we = 1'b0;
    start_cyc = cyc - 1;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk({name, " done seen"}, int'(done_cnt > 0), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic prog(input int x, input int y, input int w, input int h,
                      input logic [7:0] tile, input logic [3:0] atr);
    wr_reg(3'd0, 8'(x)); wr_reg(3'd1, 8'(y)); wr_reg(3'd2, 8'(w));
    wr_reg(3'd3, 8'(h)); wr_reg(3'd4, tile);  wr_reg(3'd5, {4'd0, atr});
  endtask

  task automatic run_fill(input string name, input int x, input int y, input int w, input int h,
                          input logic [7:0] tile, input logic [3:0] atr, input logic nt);
    int wc, hc, n, bad, i;
    logic e;
    logic [7:0] st;
    logic [10:0] ea;
    prog(x, y, w, h, tile, atr);
    start_fill({5'd0, nt, 2'b01});
    wait_done(name, 2000);
    e = (w == 0) || (h == 0) || (y > 29) || (x > 31);
    wc = 0; hc = 0;
    if (!e) begin
      wc = (w < 32 - x) ? w : 32 - x;
      hc = (h < 30 - y) ? h : 30 - y;
    end
    n = wc * hc;
    chk({name, " write count"}, wlog.size(), n);
    bad = 0; i = 0;
    for (int r = 0; r < hc; r++) begin
      for (int c = 0; c < wc; c++) begin
        ea = 11'((nt ? 1024 : 0) + (y + r) * 32 + (x + c));
        if (i < wlog.size()) begin
          if (wlog[i].addr != ea || wlog[i].dat != tile || wlog[i].atr != atr || wlog[i].rel != 2 + i)
            bad++;
        end
        i++;
      end
    end
    chk({name, " bad writes"}, bad, 0);
    chk({name, " done cycle"}, done_rel, n + 2);
    rd_reg(3'd6, st);
    chk({name, " status"}, st, int'({5'd0, nt, e, 1'b0}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_n = 1'b0; reg_we = 1'b0; reg_addr = 3'd0; reg_di = 8'd0;
    cpu_req = 1'b0; cpu_addr = 11'd0; cpu_dat = 8'd0; cpu_atr = 4'd0;
    start_cyc = 0; done_rel = -1; done_cnt = 0;

    vt[0] = '{1'b1, 3'd0, 8'hFF, 8'h1F, 1'b0};
    vt[1] = '{1'b1, 3'd1, 8'hE3, 8'h03, 1'b0};
    vt[2] = '{1'b1, 3'd2, 8'hFF, 8'h3F, 1'b0};
    vt[3] = '{1'b1, 3'd3, 8'h7F, 8'h1F, 1'b0};
    vt[4] = '{1'b1, 3'd4, 8'hA5, 8'hA5, 1'b0};
    vt[5] = '{1'b1, 3'd5, 8'hFC, 8'h0C, 1'b0};
    vt[6] = '{1'b1, 3'd7, 8'hFF, 8'h00, 1'b0};
    vt[7] = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b0};
    vt[8] = '{1'b1, 3'd6, 8'h07, 8'h00, 1'b0};
    vt[9] = '{1'b0, 3'd0, 8'h00, 8'h1F, 1'b0};

    #12;
    chk("reset ram_we", ram_we, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_dat/atr", {ram_dat, ram_atr}, 0);
    chk("reset busy/done", {busy, done}, 0);
    chk("reset reg_do", reg_do, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].we) wr_reg(vt[i].addr, vt[i].di);
      else begin @(posedge clk); #1; end
      rd_reg(vt[i].addr, v);
      chk($sformatf("vec%0d reg_do", i), v, vt[i].exp_do);
      chk($sformatf("vec%0d busy", i), busy, vt[i].exp_busy);
    end

    run_fill("full", 0, 0, 32, 30, 8'h20, 4'h5, 1'b0);
    run_fill("clip", 30, 28, 4, 4, 8'h7E, 4'h9, 1'b1);
    run_fill("w0", 3, 3, 0, 5, 8'h11, 4'h1, 1'b0);
    run_fill("y30", 0, 30, 1, 1, 8'h11, 4'h1, 1'b0);

    // CPU writes steal the port for 3 cycles mid-fill.
    prog(2, 3, 4, 1, 8'h11, 4'h3);
    cpu_addr = 11'h123; cpu_dat = 8'hAA; cpu_atr = 4'hC;
    start_fill(8'h01);
    @(posedge clk); #1;
    cpu_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cpu_req = 1'b0;
    wait_done("cpu", 200);
    cexp[0] = 11'h062; cexp[1] = 11'h123; cexp[2] = 11'h123; cexp[3] = 11'h123;
    cexp[4] = 11'h063; cexp[5] = 11'h064; cexp[6] = 11'h065;
    chk("cpu write count", wlog.size(), 7);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < wlog.size()) begin
        if (wlog[i].addr != cexp[i] || wlog[i].rel != 2 + i) bad++;
        else if (cexp[i] == 11'h123 && (wlog[i].dat != 8'hAA || wlog[i].atr != 4'hC)) bad++;
        else if (cexp[i] != 11'h123 && (wlog[i].dat != 8'h11 || wlog[i].atr != 4'h3)) bad++;
      end
    end
    chk("cpu bad writes", bad, 0);
    chk("cpu done cycle", done_rel, 9);

    // Abort written in the cycle the 5th write is on the port.
    prog(0, 0, 10, 10, 8'h44, 4'h1);
    start_fill(8'h01);
    repeat (5) @(posedge clk);
    #1;
    reg_we = 1'b1; reg_addr = 3'd6; reg_di = 8'h02;
    @(posedge clk); #1;
    reg_we = 1'b0;
    wait_done("abort", 200);
    chk("abort writes <= 6", int'(wlog.size() <= 6), 1);
    chk("abort writes >= 5", int'(wlog.size() >= 5), 1);
    chk("abort done cycle", done_rel, 7);
    rd_reg(3'd6, v);
    chk("abort status", v, 8'h00);
    run_fill("after abort", 5, 5, 2, 2, 8'h55, 4'h6, 1'b0);

    // Reset in the middle of a fill.
    prog(0, 0, 10, 10, 8'h33, 4'h2);
    start_fill(8'h01);
    repeat (8) @(posedge clk);
    #1;
    chk("pre-reset ram_we", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset ram_we/addr", {ram_we, ram_addr}, 0);
    chk("async reset ram_dat/atr", {ram_dat, ram_atr}, 0);
    chk("async reset busy/done", {busy, done}, 0);
    rd_reg(3'd4, v);
    chk("async reset tile reg", v, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wlog.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("post-reset writes", wlog.size(), 0);
    rd_reg(3'd6, v);
    chk("post-reset status", v, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
